// File: rtl/frame_pkg.sv
// Shared types and constants for the Geiger frame packer: serialiser states,
// default sync byte, CRC-8 polynomial and frame-length helper.
package frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_CHID,
        ST_TS,
        ST_DATA,
        ST_CHK
    } ser_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0] CRC8_POLY         = 8'h07;

    // Channel index field in a FIFO entry; wide enough for 16 channels.
    localparam int CH_ID_W = 4;

    function automatic int frame_len(input int ts_w, input int ch_w);
        return 3 + ts_w / 8 + ch_w / 8;
    endfunction

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_fifo.sv
// Synchronous frame FIFO with extra-bit pointers and an occupancy output.
module frame_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // A push into a full FIFO is legal only when the head leaves the same cycle.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/geiger_frame_packer.sv
// Captures timestamped channel words and serialises them as byte frames.
// Define FRAME_CRC_EN to replace the XOR check byte with CRC-8 (poly 0x07).
//
// state | meaning
// IDLE  | no frame in flight, waiting for a FIFO entry
// SYNC  | presenting the sync byte (FRAME_START high)
// CHID  | presenting the zero-extended channel index
// TS    | presenting timestamp bytes, MSB first
// DATA  | presenting channel data bytes, MSB first
// CHK   | presenting the check byte over CHID..DATA
module geiger_frame_packer
    import frame_pkg::*;
#(
    parameter int         NUM_CH     = 2,
    parameter int         CH_WIDTH   = 80,
    parameter int         TS_WIDTH   = 24,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                         CLK_1MHZ,
    input  logic                         RESET,
    input  logic [TS_WIDTH-1:0]          TIMESTAMP,
    input  logic [NUM_CH*CH_WIDTH-1:0]   CH_DATA,
    input  logic [NUM_CH-1:0]            CH_VALID,
    output logic [7:0]                   BYTE_OUT,
    output logic                         BYTE_VALID,
    input  logic                         BYTE_READY,
    output logic                         FRAME_START,
    output logic [7:0]                   DROP_COUNT,
    output logic [$clog2(FIFO_DEPTH):0]  FIFO_LEVEL
);
    localparam int         HOLD_W    = TS_WIDTH + CH_WIDTH;
    localparam int         ENTRY_W   = CH_ID_W + HOLD_W;
    localparam logic [7:0] TS_LAST   = 8'(TS_WIDTH / 8 - 1);
    localparam logic [7:0] DATA_LAST = 8'(CH_WIDTH / 8 - 1);

    logic [HOLD_W-1:0]   hold [NUM_CH];
    logic [NUM_CH-1:0]   pending;
    logic [NUM_CH-1:0]   take;
    logic [NUM_CH-1:0]   drop;
    logic                found;
    logic                push_valid;
    logic [CH_ID_W-1:0]  push_sel;
    logic [HOLD_W-1:0]   push_word;
    logic [4:0]          drop_num;
    logic [8:0]          drop_sum;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [ENTRY_W-1:0]  fifo_rdata;

    ser_state_t          state;
    logic [CH_ID_W-1:0]  sh_id;
    logic [TS_WIDTH-1:0] sh_ts;
    logic [CH_WIDTH-1:0] sh_data;
    logic [7:0]          chk;
    logic [7:0]          cnt;
    logic                fire;

    function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
`ifdef FRAME_CRC_EN
        return crc8_byte(acc, b);
`else
        return acc ^ b;
`endif
    endfunction

    // Lowest-index pending channel wins the single push slot.
    always_comb begin
        found     = 1'b0;
        push_sel  = '0;
        push_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pending[i] && !found) begin
                found     = 1'b1;
                push_sel  = CH_ID_W'(i);
                push_word = hold[i];
            end
        end
    end

    assign push_valid = found && !fifo_full;

    always_comb begin
        take     = '0;
        drop     = '0;
        drop_num = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            take[i]  = push_valid && (push_sel == CH_ID_W'(i));
            drop[i]  = CH_VALID[i] && pending[i] && !take[i];
            drop_num = drop_num + 5'(drop[i]);
        end
        drop_sum = 9'(DROP_COUNT) + 9'(drop_num);
    end

    always_ff @(posedge CLK_1MHZ or negedge RESET) begin
        if (!RESET) begin
            pending    <= '0;
            DROP_COUNT <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (CH_VALID[i] && (!pending[i] || take[i])) begin
                    hold[i]    <= {TIMESTAMP, CH_DATA[i*CH_WIDTH +: CH_WIDTH]};
                    pending[i] <= 1'b1;
                end else if (take[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            DROP_COUNT <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

    frame_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK_1MHZ),
        .rst_n (RESET),
        .push  (push_valid),
        .wdata ({push_sel, push_word}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (FIFO_LEVEL)
    );

    assign fire     = BYTE_VALID && BYTE_READY;
    assign fifo_pop = !fifo_empty && ((state == ST_IDLE) || ((state == ST_CHK) && fire));

    always_ff @(posedge CLK_1MHZ or negedge RESET) begin
        if (!RESET) begin
            state       <= ST_IDLE;
            BYTE_OUT    <= '0;
            BYTE_VALID  <= 1'b0;
            FRAME_START <= 1'b0;
            sh_id       <= '0;
            sh_ts       <= '0;
            sh_data     <= '0;
            chk         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        state       <= ST_SYNC;
                        BYTE_OUT    <= SYNC_BYTE;
                        BYTE_VALID  <= 1'b1;
                        FRAME_START <= 1'b1;
                        {sh_id, sh_ts, sh_data} <= fifo_rdata;
                        chk         <= '0;
                    end
                end
                ST_SYNC: begin
                    if (fire) begin
                        state       <= ST_CHID;
                        BYTE_OUT    <= 8'(sh_id);
                        FRAME_START <= 1'b0;
                    end
                end
                ST_CHID: begin
                    if (fire) begin
                        state    <= ST_TS;
                        chk      <= chk_next(chk, BYTE_OUT);
                        BYTE_OUT <= sh_ts[TS_WIDTH-1 -: 8];
                        sh_ts    <= sh_ts << 8;
                        cnt      <= TS_LAST;
                    end
                end
                ST_TS: begin
                    if (fire) begin
                        chk <= chk_next(chk, BYTE_OUT);
                        if (cnt == 8'd0) begin
                            state    <= ST_DATA;
                            BYTE_OUT <= sh_data[CH_WIDTH-1 -: 8];
                            sh_data  <= sh_data << 8;
                            cnt      <= DATA_LAST;
                        end else begin
                            BYTE_OUT <= sh_ts[TS_WIDTH-1 -: 8];
                            sh_ts    <= sh_ts << 8;
                            cnt      <= cnt - 8'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (fire) begin
                        if (cnt == 8'd0) begin
                            state    <= ST_CHK;
                            BYTE_OUT <= chk_next(chk, BYTE_OUT);
                        end else begin
                            chk      <= chk_next(chk, BYTE_OUT);
                            BYTE_OUT <= sh_data[CH_WIDTH-1 -: 8];
                            sh_data  <= sh_data << 8;
                            cnt      <= cnt - 8'd1;
                        end
                    end
                end
                ST_CHK: begin
                    if (fire) begin
                        // Chain straight into the next frame with no idle cycle.
                        if (fifo_pop) begin
                            state       <= ST_SYNC;
                            BYTE_OUT    <= SYNC_BYTE;
                            FRAME_START <= 1'b1;
                            {sh_id, sh_ts, sh_data} <= fifo_rdata;
                            chk         <= '0;
                        end else begin
                            state      <= ST_IDLE;
                            BYTE_OUT   <= '0;
                            BYTE_VALID <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    BYTE_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule
